// File: rtl/rpg_pkg.sv
// rpg_pkg: shared modes, FSM states and default polynomials for the rpg_prog generator.
package rpg_pkg;
   typedef enum logic [1:0] {
      RPG_LFSR = 2'b00,
      RPG_CNT  = 2'b01,
      RPG_WALK = 2'b10,
      RPG_RSVD = 2'b11
   } rpg_mode_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } rpg_state_e;

   localparam logic [7:0]  RPG_POLY8  = 8'h1D;
   localparam logic [15:0] RPG_POLY16 = 16'h002D;
endpackage

// File: rtl/rpg_step.sv
// rpg_step: combinational next-pattern function; the reserved mode falls through to LFSR.
module rpg_step
   import rpg_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] pat_i,
   input  logic [WIDTH-1:0] poly_i,
   input  rpg_mode_e        mode_i,
   output logic [WIDTH-1:0] next_o
);
   always_comb begin
      next_o = mode_i == RPG_CNT  ? pat_i + WIDTH'(1) :
               mode_i == RPG_WALK ? {pat_i[WIDTH-2:0], pat_i[WIDTH-1]} :
                                    (pat_i << 1) ^ ({WIDTH{pat_i[WIDTH-1]}} & poly_i);
   end
endmodule

// File: rtl/rpg_prog.sv
// rpg_prog: programmable LBIST pattern generator (LFSR / counter / walking-one)
// with seed load, pause, pattern count and busy/valid/done status.
module rpg_prog
   import rpg_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             seed_load,
   input  logic [WIDTH-1:0] seed,
   input  logic [WIDTH-1:0] poly,
   input  logic [1:0]       mode,
   input  logic [CNT_W-1:0] num_patterns,
   input  logic             pause,
   output logic [WIDTH-1:0] pattern,
   output logic             valid,
   output logic             busy,
   output logic             done
);
   rpg_state_e       state_q, state_d;
   rpg_mode_e        mode_q, mode_d;
   logic [WIDTH-1:0] pat_q, pat_d, poly_q, poly_d, base, step;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             accept, adv, last;

   rpg_step #(.WIDTH(WIDTH)) u_step (
      .pat_i  (pat_q),
      .poly_i (poly_q),
      .mode_i (mode_q),
      .next_o (step)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         mode_q  <= RPG_LFSR;
         poly_q  <= '0;
         pat_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         poly_q  <= poly_d;
         pat_q   <= pat_d;
         cnt_q   <= cnt_d;
      end
   end

   // Zero is a lock-up value for LFSR and walking-one, so a zero start value is bumped to 1.
   always_comb begin
      base    = seed_load ? seed : pat_q;
      accept  = start && state_q != ST_RUN;
      adv     = state_q == ST_RUN && !pause;
      last    = cnt_q == CNT_W'(1);
      state_d = accept ? (num_patterns == '0 ? ST_DONE : ST_RUN) :
                adv && last ? ST_DONE : state_q;
      mode_d  = accept ? rpg_mode_e'(mode) : mode_q;
      poly_d  = accept ? poly : poly_q;
      cnt_d   = accept ? num_patterns : adv ? cnt_q - CNT_W'(1) : cnt_q;
      pat_d   = accept ? ((base == '0 && rpg_mode_e'(mode) != RPG_CNT) ? WIDTH'(1) : base) :
                adv && !last ? step : pat_q;
   end

   assign pattern = pat_q;
   assign valid   = adv;
   assign busy    = state_q == ST_RUN;
   assign done    = state_q == ST_DONE;
endmodule

// File: tb/tb_rpg_prog.sv
// tb_rpg_prog: table vectors, directed corner sequences and random stimulus
// checked against a queue-based run model of the generator.
module tb_rpg_prog;
   logic        clk = 1'b0;
   logic        rst, start, seed_load, pause;
   logic [7:0]  seed, poly, pattern;
   logic [1:0]  mode;
   logic [15:0] num_patterns;
   logic        valid, busy, done;

   always #5 clk = ~clk;

   rpg_prog #(.WIDTH(8), .CNT_W(16)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .seed_load    (seed_load),
      .seed         (seed),
      .poly         (poly),
      .mode         (mode),
      .num_patterns (num_patterns),
      .pause        (pause),
      .pattern      (pattern),
      .valid        (valid),
      .busy         (busy),
      .done         (done)
   );

   typedef struct {
      logic        st;
      logic        sl;
      logic [7:0]  sd;
      logic [7:0]  pl;
      logic [1:0]  md;
      logic [15:0] n;
      logic        pz;
      logic [7:0]  e_pat;
      logic        e_v;
      logic        e_b;
      logic        e_d;
   } vec_t;

   vec_t       tbl[12];
   int         n_chk = 0;
   int         n_fail = 0;
   logic [7:0] q[$];
   logic       m_run = 1'b0;
   logic       m_done = 1'b0;
   logic [7:0] m_pat = 8'h00;

   function automatic logic [7:0] nxt(input logic [7:0] r, input logic [7:0] p, input logic [1:0] m);
      int v;
      v = int'(r);
      if (m == 2'd1) return 8'((v + 1) % 256);
      if (m == 2'd2) return 8'((v * 2) % 256 + v / 128);
      return 8'(((v * 2) % 256) ^ (v >= 128 ? int'(p) : 0));
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic drive(input logic st, input logic sl, input logic [7:0] sd, input logic [7:0] pl,
                        input logic [1:0] md, input logic [15:0] n, input logic pz);
      start = st; seed_load = sl; seed = sd; poly = pl; mode = md; num_patterns = n; pause = pz;
   endtask

   task automatic check_model();
      chk("pattern", pattern, m_pat);
      chk("valid", valid, m_run && !pause);
      chk("busy", busy, m_run);
      chk("done", done, m_done);
   endtask

   // On an accepted start the whole run is precomputed; each unpaused run cycle consumes one entry.
   task automatic adv();
      logic [7:0] r, g;
      if (!m_run && start) begin
         g = seed_load ? seed : m_pat;
         if (g == 8'h00 && mode != 2'd1) g = 8'h01;
         q.delete();
         r = g;
         for (int i = 0; i < int'(num_patterns); i++) begin
            q.push_back(r);
            r = nxt(r, poly, mode);
         end
         m_pat  = g;
         m_run  = num_patterns != 0;
         m_done = num_patterns == 0;
      end else if (m_run && !pause) begin
         void'(q.pop_front());
         if (q.size() == 0) begin
            m_run  = 1'b0;
            m_done = 1'b1;
         end else m_pat = q[0];
      end
      @(negedge clk);
   endtask

   task automatic cyc(input logic st, input logic sl, input logic [7:0] sd, input logic [7:0] pl,
                      input logic [1:0] md, input logic [15:0] n, input logic pz);
      drive(st, sl, sd, pl, md, n, pz);
      #1;
      check_model();
      adv();
   endtask

   task automatic idle();
      cyc(1'b0, 1'b0, 8'h00, 8'h00, 2'd0, 16'd0, 1'b0);
   endtask

   task automatic run_tbl();
      for (int i = 0; i < 12; i++) begin
         drive(tbl[i].st, tbl[i].sl, tbl[i].sd, tbl[i].pl, tbl[i].md, tbl[i].n, tbl[i].pz);
         #1;
         check_model();
         chk("tbl_pattern", pattern, tbl[i].e_pat);
         chk("tbl_valid", valid, tbl[i].e_v);
         chk("tbl_busy", busy, tbl[i].e_b);
         chk("tbl_done", done, tbl[i].e_d);
         adv();
      end
   endtask

   initial begin
      logic [7:0] ce[4];
      logic [7:0] we[3];
      logic [7:0] lfsr_seq[10];
      logic       seen[256];
      logic [7:0] last_pat;
      int         dup, k;
      ce = '{8'hFE, 8'hFF, 8'h00, 8'h01};
      we = '{8'h80, 8'h01, 8'h02};
      lfsr_seq = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1D, 8'h3A};
      tbl[0] = '{1'b1, 1'b1, 8'h01, 8'h1D, 2'd0, 16'd10, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
      for (int i = 0; i < 10; i++)
         tbl[i+1] = '{1'b0, 1'b0, 8'h00, 8'h00, 2'd0, 16'd0, 1'b0, lfsr_seq[i], 1'b1, 1'b1, 1'b0};
      tbl[11] = '{1'b0, 1'b0, 8'h00, 8'h00, 2'd0, 16'd0, 1'b0, 8'h3A, 1'b0, 1'b0, 1'b1};

      rst = 1'b1;
      drive(1'b0, 1'b0, 8'h00, 8'h00, 2'd0, 16'd0, 1'b0);
      repeat (2) @(negedge clk);
      chk("rst_pattern", pattern, 8'h00);
      chk("rst_valid", valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      rst = 1'b0;
      @(negedge clk);

      run_tbl();

      cyc(1'b1, 1'b1, 8'hFE, 8'h00, 2'd1, 16'd4, 1'b0);
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b0, 8'h00, 8'h00, 2'd0, 16'd0, 1'b0);
         #1;
         chk("cnt_pattern", pattern, ce[i]);
         chk("cnt_valid", valid, 1'b1);
         check_model();
         adv();
      end
      idle();

      cyc(1'b1, 1'b1, 8'h80, 8'h00, 2'd2, 16'd3, 1'b0);
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b0, 8'h00, 8'h00, 2'd0, 16'd0, 1'b0);
         #1;
         chk("walk_pattern", pattern, we[i]);
         check_model();
         adv();
      end
      idle();

      cyc(1'b1, 1'b1, 8'h00, 8'h1D, 2'd0, 16'd255, 1'b0);
      dup = 0;
      for (int i = 0; i < 256; i++) seen[i] = 1'b0;
      for (int i = 0; i < 255; i++) begin
         drive(1'b0, 1'b0, 8'h00, 8'h00, 2'd0, 16'd0, 1'b0);
         #1;
         if (i == 0) chk("lfsr_zero_seed", pattern, 8'h01);
         if (seen[pattern]) dup++;
         seen[pattern] = 1'b1;
         last_pat = pattern;
         check_model();
         adv();
      end
      chk("lfsr_no_repeat", dup, 0);
      cyc(1'b1, 1'b0, 8'h55, 8'h1D, 2'd0, 16'd3, 1'b0);
      drive(1'b0, 1'b0, 8'h00, 8'h00, 2'd0, 16'd0, 1'b0);
      #1;
      chk("cont_reissue", pattern, last_pat);
      check_model();
      adv();
      drive(1'b0, 1'b0, 8'h00, 8'h00, 2'd0, 16'd0, 1'b0);
      #1;
      chk("cont_wrap", pattern, 8'h01);
      check_model();
      adv();
      repeat (2) idle();

      cyc(1'b1, 1'b1, 8'h10, 8'h00, 2'd1, 16'd6, 1'b0);
      k = -1;
      for (int i = 0; i < 20; i++) begin
         drive(1'b0, 1'b0, 8'h00, 8'h00, 2'd0, 16'd0, i >= 2 && i < 5);
         #1;
         if (done && k < 0) k = i + 1;
         check_model();
         adv();
      end
      chk("pause_done_cycle", k, 10);

      cyc(1'b1, 1'b1, 8'h55, 8'h1D, 2'd0, 16'd0, 1'b0);
      drive(1'b0, 1'b0, 8'h00, 8'h00, 2'd0, 16'd0, 1'b0);
      #1;
      chk("n0_done", done, 1'b1);
      chk("n0_busy", busy, 1'b0);
      chk("n0_valid", valid, 1'b0);
      check_model();
      adv();

      cyc(1'b1, 1'b1, 8'h00, 8'h00, 2'd1, 16'd5, 1'b0);
      idle();
      cyc(1'b1, 1'b1, 8'hAA, 8'h00, 2'd2, 16'd2, 1'b0);
      drive(1'b0, 1'b0, 8'h00, 8'h00, 2'd0, 16'd0, 1'b0);
      #1;
      chk("run_start_ignored", pattern, 8'h02);
      check_model();
      adv();
      repeat (4) idle();

      cyc(1'b1, 1'b1, 8'h01, 8'h1D, 2'd0, 16'd10, 1'b0);
      repeat (3) idle();
      drive(1'b0, 1'b0, 8'h00, 8'h00, 2'd0, 16'd0, 1'b0);
      #1 rst = 1'b1;
      #1;
      chk("midrst_pattern", pattern, 8'h00);
      chk("midrst_valid", valid, 1'b0);
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_done", done, 1'b0);
      #1 rst = 1'b0;
      q.delete();
      m_run = 1'b0;
      m_done = 1'b0;
      m_pat = 8'h00;
      @(negedge clk);
      run_tbl();

      for (int i = 0; i < 400; i++)
         cyc($urandom_range(0, 3) == 0, 1'($urandom), 8'($urandom),
             ($urandom % 2) ? 8'h1D : 8'($urandom), 2'($urandom),
             16'($urandom_range(0, 12)), $urandom_range(0, 4) == 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
